// File: rtl/axi_rd_burst_arbiter.sv
// Two-requester AXI3 read arbiter: round-robin per burst, one burst in flight,
// R beats routed to the granted requester, sticky burst-length mismatch flag.
module axi_rd_burst_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              bus_clk,
    input  logic              bus_rst,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [3:0]        s0_arlen,
    input  logic [2:0]        s0_arsize,
    input  logic [1:0]        s0_arburst,
    input  logic [2:0]        s0_arprot,
    input  logic [3:0]        s0_arcache,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [3:0]        s1_arlen,
    input  logic [2:0]        s1_arsize,
    input  logic [1:0]        s1_arburst,
    input  logic [2:0]        s1_arprot,
    input  logic [3:0]        s1_arcache,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [3:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arcache,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              err_clr,
    output logic              err,
    output logic              busy
);

    localparam int AR_W = ADDR_W + 4 + 3 + 2 + 3 + 4;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t          state_reg, state_next;
    logic            rr_reg, rr_next;
    logic            gnt_reg, gnt_next;
    logic [4:0]      cnt_reg, cnt_next;
    logic            err_reg, err_next;
    logic [AR_W-1:0] ar_reg, ar_next;

    logic [AR_W-1:0] ar_req [2];
    logic [1:0]      arvalid_v, rready_v, arready_v, rvalid_v;
    logic            win, grant, hs, mismatch;

    assign ar_req[0] = {s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arprot, s0_arcache};
    assign ar_req[1] = {s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arprot, s1_arcache};
    assign arvalid_v = {s1_arvalid, s0_arvalid};
    assign rready_v  = {s1_rready, s0_rready};

    // With both requesting, rr picks; otherwise whoever is asking.
    assign win   = (arvalid_v == 2'b11) ? rr_reg : arvalid_v[1];
    assign grant = (state_reg == IDLE) && (arvalid_v != 2'b00) && !bus_rst;

    assign m_axi_rready = (state_reg == DATA) && rready_v[gnt_reg];
    assign hs           = (state_reg == DATA) && m_axi_rvalid && m_axi_rready;

    // cnt counts beats already accepted, so the final beat must see cnt == arlen.
    assign mismatch = hs && (m_axi_rlast ? (cnt_reg != {1'b0, m_axi_arlen})
                                         : (cnt_reg >= {1'b0, m_axi_arlen}));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign arready_v[gi] = grant && (win == 1'(gi));
            assign rvalid_v[gi]  = (state_reg == DATA) && (gnt_reg == 1'(gi)) && m_axi_rvalid;
        end
    endgenerate

    assign s0_arready = arready_v[0];
    assign s1_arready = arready_v[1];
    assign s0_rvalid  = rvalid_v[0];
    assign s1_rvalid  = rvalid_v[1];
    assign s0_rdata   = m_axi_rdata;
    assign s1_rdata   = m_axi_rdata;
    assign s0_rresp   = m_axi_rresp;
    assign s1_rresp   = m_axi_rresp;
    assign s0_rlast   = m_axi_rlast;
    assign s1_rlast   = m_axi_rlast;

    assign {m_axi_araddr, m_axi_arlen, m_axi_arsize,
            m_axi_arburst, m_axi_arprot, m_axi_arcache} = ar_reg;
    assign m_axi_arvalid = (state_reg == ADDR);
    assign busy          = (state_reg != IDLE);
    assign err           = err_reg;

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        gnt_next   = gnt_reg;
        cnt_next   = cnt_reg;
        ar_next    = ar_reg;
        case (state_reg)
            IDLE: begin
                if (arvalid_v != 2'b00) begin
                    ar_next    = ar_req[win];
                    gnt_next   = win;
                    cnt_next   = 5'd0;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (m_axi_arready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (hs) begin
                    if (cnt_reg != 5'd16) begin
                        cnt_next = cnt_reg + 5'd1;
                    end
                    if (m_axi_rlast) begin
                        state_next = IDLE;
                        rr_next    = ~gnt_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A fresh mismatch outranks a same-cycle clear.
        err_next = mismatch ? 1'b1 : (err_clr ? 1'b0 : err_reg);
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
            gnt_reg   <= 1'b0;
            cnt_reg   <= 5'd0;
            err_reg   <= 1'b0;
            ar_reg    <= '0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            gnt_reg   <= gnt_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            ar_reg    <= ar_next;
        end
    end

endmodule

// File: tb/tb_axi_rd_burst_arbiter.sv
// Bench for axi_rd_burst_arbiter: directed bring-up, mid-burst reset, then
// randomized requesters and slave checked against a burst-level model.
module tb_axi_rd_burst_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [2:0]  prot;
        logic [3:0]  cache;
    } ar_t;

    logic bus_clk = 1'b0;
    logic bus_rst;
    always #5 bus_clk = ~bus_clk;

    ar_t             s_ar [2];
    logic [1:0]      s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [1:0][31:0] s_rdata;
    logic [1:0][1:0] s_rresp;
    logic            m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [31:0]     m_axi_araddr, m_axi_rdata;
    logic [3:0]      m_axi_arlen, m_axi_arcache;
    logic [2:0]      m_axi_arsize, m_axi_arprot;
    logic [1:0]      m_axi_arburst, m_axi_rresp;
    logic            err_clr, err, busy;

    axi_rd_burst_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .bus_clk(bus_clk), .bus_rst(bus_rst),
        .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]),
        .s0_araddr(s_ar[0].addr), .s0_arlen(s_ar[0].len), .s0_arsize(s_ar[0].size),
        .s0_arburst(s_ar[0].burst), .s0_arprot(s_ar[0].prot), .s0_arcache(s_ar[0].cache),
        .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]), .s0_rdata(s_rdata[0]),
        .s0_rresp(s_rresp[0]), .s0_rlast(s_rlast[0]),
        .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]),
        .s1_araddr(s_ar[1].addr), .s1_arlen(s_ar[1].len), .s1_arsize(s_ar[1].size),
        .s1_arburst(s_ar[1].burst), .s1_arprot(s_ar[1].prot), .s1_arcache(s_ar[1].cache),
        .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]), .s1_rdata(s_rdata[1]),
        .s1_rresp(s_rresp[1]), .s1_rlast(s_rlast[1]),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot), .m_axi_arcache(m_axi_arcache),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .err_clr(err_clr), .err(err), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Burst-level reference state: who owns the bus, whether the address is
    // still outstanding, how many beats have gone by, and the sticky flag.
    bit   pend [2];
    bit   m_rr, m_busy, m_addr, m_data, m_err, own;
    ar_t  cur;
    int   k, rcv, sl_total, sl_idx, nbursts;
    bit   bv, b_last;
    logic [31:0] b_data;
    logic [1:0]  b_resp;
    int   grants [$];

    // Stimulus knobs
    int req_pct [2];
    int len_fixed, ar_pct, rv_pct, err_pct, clr_pct;
    bit rr_toggle;

    task automatic model_reset();
        pend[0] = 0; pend[1] = 0;
        m_rr = 0; m_busy = 0; m_addr = 0; m_data = 0; m_err = 0; own = 0;
        bv = 0; k = 0; rcv = 0; sl_idx = 0; sl_total = 0;
    endtask

    task automatic step();
        bit grant, w, hs, set_err;
        @(negedge bus_clk);
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(99) < req_pct[i]) begin
                s_ar[i].addr  = $urandom;
                s_ar[i].len   = (len_fixed >= 0) ? 4'(len_fixed) : 4'($urandom_range(15));
                s_ar[i].size  = 3'($urandom_range(7));
                s_ar[i].burst = 2'($urandom_range(3));
                s_ar[i].prot  = 3'($urandom_range(7));
                s_ar[i].cache = 4'($urandom_range(15));
                pend[i] = 1;
            end
        end
        s_arvalid     = {pend[1], pend[0]};
        err_clr       = ($urandom_range(99) < clr_pct);
        m_axi_arready = ($urandom_range(99) < ar_pct);
        if (m_data) begin
            if (!bv && $urandom_range(99) < rv_pct) begin
                bv     = 1;
                b_data = $urandom;
                b_resp = 2'($urandom_range(3));
                b_last = (sl_idx == sl_total - 1);
            end
            m_axi_rvalid = bv;
            m_axi_rdata  = b_data;
            m_axi_rresp  = b_resp;
            m_axi_rlast  = b_last;
        end else begin
            // Stray beats outside a data phase must be ignored.
            m_axi_rvalid = 1'($urandom_range(1));
            m_axi_rdata  = $urandom;
            m_axi_rresp  = 2'($urandom_range(3));
            m_axi_rlast  = 1'($urandom_range(1));
        end
        if (rr_toggle) s_rready = ~s_rready;
        else           s_rready = 2'($urandom_range(3));
        #1;

        grant = !m_busy && (pend[0] || pend[1]);
        w     = (pend[0] && pend[1]) ? m_rr : pend[1];
        check("arready0", s_arready[0], grant && !w);
        check("arready1", s_arready[1], grant && w);
        check("busy", busy, m_busy);
        check("err", err, m_err);
        check("m_arvalid", m_axi_arvalid, m_addr);
        if (m_addr)
            check("ar_fields", {m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                                m_axi_arprot, m_axi_arcache}, cur);
        if (m_data) begin
            check("m_rready", m_axi_rready, s_rready[own]);
            check("rvalid_own", s_rvalid[own], m_axi_rvalid);
            check("rvalid_other", s_rvalid[~own], 0);
            if (m_axi_rvalid)
                check("r_payload", {s_rdata[own], s_rresp[own], s_rlast[own]},
                      {b_data, b_resp, b_last});
            if (s_rvalid[own] && s_rready[own]) rcv++;
        end else begin
            check("m_rready_idle", m_axi_rready, 0);
            check("rvalid_idle", s_rvalid, 0);
        end

        set_err = 0;
        hs = m_data && bv && s_rready[own];
        if (hs) begin
            // Beat k (0-based) may carry rlast only when k == len, and must when k == len.
            if (b_last ? (k != int'(cur.len)) : (k >= int'(cur.len))) set_err = 1;
            k++;
            sl_idx++;
            bv = 0;
            if (b_last) begin
                check("beats", rcv, sl_total);
                nbursts++;
                $display("burst %0d req=%0d addr=0x%08h len=%0d beats=%0d",
                         nbursts, own, cur.addr, cur.len, k);
                m_busy = 0;
                m_data = 0;
                m_rr   = ~own;
            end
        end
        if (m_addr && m_axi_arready) begin
            m_addr   = 0;
            m_data   = 1;
            sl_idx   = 0;
            bv       = 0;
            sl_total = int'(cur.len) + 1;
            if ($urandom_range(99) < err_pct) begin
                do sl_total = $urandom_range(17, 1); while (sl_total == int'(cur.len) + 1);
            end
        end
        if (grant) begin
            m_busy = 1;
            m_addr = 1;
            own    = w;
            cur    = s_ar[w];
            pend[w] = 0;
            k      = 0;
            rcv    = 0;
            grants.push_back(int'(w));
        end
        m_err = set_err ? 1'b1 : (err_clr ? 1'b0 : m_err);
    endtask

    task automatic drain();
        req_pct[0] = 0; req_pct[1] = 0;
        for (int c = 0; c < 3000 && (m_busy || pend[0] || pend[1]); c++) step();
        check("drain", {m_busy, pend[0], pend[1]}, 3'b000);
    endtask

    task automatic idle_inputs();
        s_arvalid = 2'b00; s_rready = 2'b00; err_clr = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
    endtask

    int exp_order [4];

    initial begin
        exp_order = '{0, 1, 0, 1};
        nbursts = 0;
        s_ar[0] = '0; s_ar[1] = '0;
        idle_inputs();
        model_reset();
        bus_rst = 1;
        repeat (3) @(negedge bus_clk);
        bus_rst = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_outs", {m_axi_arvalid, m_axi_rready, err, s_rvalid, s_arready}, 0);
        check("rst_ar", {m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                         m_axi_arprot, m_axi_arcache}, 0);

        // Single s0 burst of 4 beats.
        @(negedge bus_clk);
        s_ar[0] = '{addr: 32'h1000, len: 4'd3, size: 3'd2, burst: 2'd1, prot: 3'd0, cache: 4'd3};
        s_arvalid = 2'b01;
        #1;
        check("t1_arready0", s_arready[0], 1);
        check("t1_arready1", s_arready[1], 0);
        @(negedge bus_clk);
        s_arvalid = 2'b00;
        m_axi_arready = 1;
        #1;
        check("t1_arready_pulse", s_arready[0], 0);
        check("t1_arvalid", m_axi_arvalid, 1);
        check("t1_araddr", m_axi_araddr, 32'h1000);
        check("t1_arlen", m_axi_arlen, 3);
        @(negedge bus_clk);
        m_axi_arready = 0;
        s_rready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge bus_clk);
            m_axi_rvalid = 1;
            m_axi_rdata  = 32'hA0 + i;
            m_axi_rlast  = (i == 3);
            #1;
            if (i == 0) check("t1_arvalid_drop", m_axi_arvalid, 0);
            check("t1_rvalid0", s_rvalid[0], 1);
            check("t1_rvalid1", s_rvalid[1], 0);
            check("t1_rdata", s_rdata[0], 32'hA0 + i);
            check("t1_rlast", s_rlast[0], i == 3);
        end
        @(negedge bus_clk);
        m_axi_rvalid = 0; m_axi_rlast = 0;
        #1;
        check("t1_busy_after", busy, 0);
        check("t1_err", err, 0);

        // s0 again (rr now favours s1), reset after the first beat.
        @(negedge bus_clk);
        s_arvalid = 2'b01;
        @(negedge bus_clk);
        s_arvalid = 2'b00;
        m_axi_arready = 1;
        @(negedge bus_clk);
        m_axi_arready = 0;
        m_axi_rvalid = 1; m_axi_rdata = 32'hB0; m_axi_rlast = 0;
        #1;
        check("rst_mid_beat", s_rvalid[0], 1);
        @(negedge bus_clk);
        bus_rst = 1;
        @(negedge bus_clk);
        bus_rst = 0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rready", m_axi_rready, 0);
        check("rst_mid_arready", s_arready, 0);
        idle_inputs();
        model_reset();

        // Both requesters always asking: rr must start at 0 after reset.
        req_pct[0] = 100; req_pct[1] = 100;
        len_fixed = -1; ar_pct = 70; rv_pct = 70; err_pct = 0; clr_pct = 0; rr_toggle = 0;
        grants.delete();
        for (int c = 0; c < 3000 && grants.size() < 6; c++) step();
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) check("grant_order", grants[i], exp_order[i]);
            else check("grant_count", grants.size(), 4);
        end
        drain();

        // s1 only, 16-beat bursts, slow AR and toggling rready.
        req_pct[0] = 0; req_pct[1] = 100;
        len_fixed = 15; ar_pct = 15; rv_pct = 100; rr_toggle = 1;
        for (int c = 0; c < 120; c++) step();
        drain();

        // Fully random traffic with length errors and err_clr at any time.
        req_pct[0] = 40; req_pct[1] = 40;
        len_fixed = -1; ar_pct = 50; rv_pct = 60; err_pct = 35; clr_pct = 20; rr_toggle = 0;
        for (int c = 0; c < 2500; c++) step();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
